// File: rtl/four_request_rr_arbiter.sv
// Four-way round-robin arbiter: one-hot registered grant, held until the owner
// releases (done or dropped request) or the hold timeout expires.
module four_request_rr_arbiter #(
  parameter int CNT_W    = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic       any_req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_SAT   = '1;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       grant_idx_q, grant_idx_d;

  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       found;
  logic       timeout_hit;
  logic       release_now;

  assign any_req = |req;

  // Rotating priority scan: the first active line at or after ptr wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign timeout_hit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIMIT);
  assign release_now = done || !req[grant_idx_q] || timeout_hit;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          grant_d     = 4'b0001 << pick_idx;
          grant_idx_d = pick_idx;
          hold_cnt_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = IDLE;
          grant_d    = 4'b0000;
          ptr_d      = grant_idx_q + 2'd1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      grant_q     <= 4'b0000;
      grant_idx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_four_request_rr_arbiter.sv
// Scoreboard bench for four_request_rr_arbiter: a behavioural model queues the
// expected outputs per edge, a monitor compares them against the DUT.
module tb_four_request_rr_arbiter;

  localparam int CNT_W = 4;
  localparam int HOLD  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       any_req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  four_request_rr_arbiter #(.CNT_W(CNT_W), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .any_req(any_req), .grant(grant), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] idx;
    logic       bsy;
    logic       anyr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: owner index, rotation start, cycles held so far.
  bit m_active = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_hold = 0;

  function automatic void model_step(input logic r, input logic [3:0] rq, input logic d);
    if (r) begin
      m_active = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_active) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!m_active && rq[j]) begin
          m_active = 1; m_idx = j; m_hold = 1;
        end
      end
    end else begin
      if (d || !rq[m_idx] || (HOLD != 0 && m_hold == HOLD)) begin
        m_active = 0; m_ptr = (m_idx + 1) % 4; m_hold = 0;
      end else if (m_hold < (1 << CNT_W) - 1) begin
        m_hold = m_hold + 1;
      end
    end
  endfunction

  task automatic drive(input logic r, input logic [3:0] rq, input logic d);
    exp_t e;
    reset = r; req = rq; done = d;
    model_step(r, rq, d);
    e.g    = m_active ? (4'b0001 << m_idx) : 4'b0000;
    e.idx  = 2'(m_idx);
    e.bsy  = m_active;
    e.anyr = |rq;
    exp_q.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", int'(grant), int'(e.g));
        chk("grant_idx", int'(grant_idx), int'(e.idx));
        chk("busy", int'(busy), int'(e.bsy));
        chk("any_req", int'(any_req), int'(e.anyr));
        chk("busy_vs_grant", int'(busy), int'(|grant));
        chk("onehot0", int'($onehot0(grant)), 1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, expected end by 500000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] rq;
    // reset with all requests high
    drive(1, 4'b1111, 0);
    drive(1, 4'b1111, 0);
    // single request on line 2, then done
    drive(0, 4'b0100, 0);
    drive(0, 4'b0100, 1);
    drive(0, 4'b0000, 0);
    // full contention with done one cycle after each grant
    drive(1, 4'b0000, 0);
    for (int i = 0; i < 12; i++) drive(0, 4'b1111, logic'(m_active));
    // timeout: lines 0 and 1 held, done never asserted
    drive(1, 4'b0000, 0);
    for (int i = 0; i < 12; i++) drive(0, 4'b0011, 0);
    // drop request of owner on line 1, then wrap-around scan
    drive(1, 4'b0000, 0);
    drive(0, 4'b0001, 0);
    drive(0, 4'b0001, 1);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0010, 0);
    drive(0, 4'b0010, 0);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0011, 0);
    drive(0, 4'b0011, 0);
    // reset in the middle of a grant on line 3
    drive(1, 4'b0000, 0);
    drive(0, 4'b1000, 0);
    drive(0, 4'b1000, 0);
    drive(1, 4'b1001, 0);
    drive(0, 4'b1001, 0);
    drive(0, 4'b1001, 0);
    // done while idle is ignored
    drive(0, 4'b0000, 1);
    drive(0, 4'b0000, 1);
    // randomized traffic
    rq = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 0) rq = 4'($urandom_range(0, 15));
      drive(logic'($urandom_range(0, 63) == 0), rq, logic'($urandom_range(0, 3) == 0));
    end
    drive(0, 4'b0000, 0);
    @(posedge clk); #3;
    chk("queue_drained", exp_q.size(), 0);
    checks++;
    if (checks < 12000) begin
      errors++;
      $display("FAIL check_count: got %0d expected at least 12000", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
